// File: rtl/demux_buffer.sv
// One input stream split onto two independently buffered output ports.
// Condition = 0 routes to port 1, Condition = 1 routes to port 2.
module demux_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     In_Valid,
  output logic                     In_Ready,
  input  logic                     Condition,
  input  logic [WIDTH-1:0]         Data,
  output logic                     Out1_Valid,
  input  logic                     Out1_Ready,
  output logic [WIDTH-1:0]         Data1,
  output logic                     Out2_Valid,
  input  logic                     Out2_Ready,
  output logic [WIDTH-1:0]         Data2,
  output logic [$clog2(DEPTH):0]   Count1,
  output logic [$clog2(DEPTH):0]   Count2
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // In_Ready depends only on registered occupancy, never on output readies,
  // so a pop on a full buffer frees space one cycle later.
  logic             accept;
  logic             out_ready [2];
  logic [CW-1:0]    cnt       [2];
  logic [WIDTH-1:0] head      [2];

  assign out_ready[0] = Out1_Ready;
  assign out_ready[1] = Out2_Ready;

  assign In_Ready = (Condition ? cnt[1] : cnt[0]) != FULL;
  assign accept   = In_Valid && In_Ready;

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

    assign push = accept && (Condition == 1'(p));
    assign pop  = (count != '0) && out_ready[p];

    // Pointers are AW bits wide, so DEPTH being a power of two makes them wrap for free.
    always_ff @(posedge CLK) begin
      if (Reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= Data;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end

    assign cnt[p]  = count;
    assign head[p] = mem[rd_ptr];
  end

  assign Count1     = cnt[0];
  assign Count2     = cnt[1];
  assign Out1_Valid = cnt[0] != '0;
  assign Out2_Valid = cnt[1] != '0;
  assign Data1      = head[0];
  assign Data2      = head[1];

endmodule

// File: tb/tb_demux_buffer.sv
// Scoreboard bench for demux_buffer: per-port expected queues fed on accept,
// compared against the port head every cycle and popped on each output transfer.
module tb_demux_buffer;

  localparam int W     = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          CLK;
  logic          Reset;
  logic          In_Valid;
  logic          In_Ready;
  logic          Condition;
  logic [W-1:0]  Data;
  logic          Out1_Valid;
  logic          Out1_Ready;
  logic [W-1:0]  Data1;
  logic          Out2_Valid;
  logic          Out2_Ready;
  logic [W-1:0]  Data2;
  logic [CW-1:0] Count1;
  logic [CW-1:0] Count2;

  logic [W-1:0] exp1_q[$];
  logic [W-1:0] exp2_q[$];

  int checks = 0;
  int errors = 0;

  demux_buffer #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .Reset(Reset),
    .In_Valid(In_Valid), .In_Ready(In_Ready), .Condition(Condition), .Data(Data),
    .Out1_Valid(Out1_Valid), .Out1_Ready(Out1_Ready), .Data1(Data1),
    .Out2_Valid(Out2_Valid), .Out2_Ready(Out2_Ready), .Data2(Data2),
    .Count1(Count1), .Count2(Count2)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic c, input logic [W-1:0] d);
    In_Valid  = v;
    Condition = c;
    Data      = d;
  endtask

  // Scoreboard: evaluated mid-cycle, i.e. with the inputs the next edge will see.
  always @(negedge CLK) begin
    if (Reset) begin
      exp1_q.delete();
      exp2_q.delete();
    end else begin
      logic exp_rdy;
      exp_rdy = Condition ? (exp2_q.size() < DEPTH) : (exp1_q.size() < DEPTH);
      check("in_ready", W'(In_Ready), W'(exp_rdy));
      check("count1", W'(Count1), W'(exp1_q.size()));
      check("count2", W'(Count2), W'(exp2_q.size()));
      check("out1_valid", W'(Out1_Valid), W'(exp1_q.size() != 0));
      check("out2_valid", W'(Out2_Valid), W'(exp2_q.size() != 0));
      if (exp1_q.size() != 0) check("data1_head", Data1, exp1_q[0]);
      if (exp2_q.size() != 0) check("data2_head", Data2, exp2_q[0]);
      if (exp1_q.size() != 0 && Out1_Ready) void'(exp1_q.pop_front());
      if (exp2_q.size() != 0 && Out2_Ready) void'(exp2_q.pop_front());
      if (In_Valid && exp_rdy) begin
        if (Condition) exp2_q.push_back(Data);
        else           exp1_q.push_back(Data);
      end
    end
  end

  task automatic drain(input string tag);
    Out1_Ready = 1'b1;
    Out2_Ready = 1'b1;
    drive(1'b0, 1'b0, '0);
    for (int k = 0; k < 50 && (exp1_q.size() != 0 || exp2_q.size() != 0); k++) cycle();
    check(tag, W'({Out1_Valid, Out2_Valid}), '0);
  endtask

  initial begin
    Reset      = 1'b1;
    Out1_Ready = 1'b0;
    Out2_Ready = 1'b0;
    drive(1'b0, 1'b0, '0);
    repeat (2) cycle();
    Reset = 1'b0;

    // reset state
    check("rst_count1", W'(Count1), '0);
    check("rst_count2", W'(Count2), '0);
    check("rst_valid", W'({Out1_Valid, Out2_Valid}), '0);
    check("rst_data1", Data1, '0);
    check("rst_data2", Data2, '0);
    Condition = 1'b0; #1;
    check("rst_ready_c0", W'(In_Ready), W'(1));
    Condition = 1'b1; #1;
    check("rst_ready_c1", W'(In_Ready), W'(1));

    // routing with both consumers ready
    Out1_Ready = 1'b1;
    Out2_Ready = 1'b1;
    drive(1'b1, 1'b0, 32'h1111_1111);
    cycle();
    check("route_data1", Data1, 32'h1111_1111);
    check("route_valid1", W'(Out1_Valid), W'(1));
    drive(1'b1, 1'b1, 32'h2222_2222);
    cycle();
    check("route_data2", Data2, 32'h2222_2222);
    check("route_count1", W'(Count1), '0);
    drive(1'b0, 1'b0, '0);
    cycle();
    check("route_count2", W'(Count2), '0);

    // fill port 1
    Out1_Ready = 1'b0;
    drive(1'b1, 1'b0, 32'hA0); cycle();
    drive(1'b1, 1'b0, 32'hA1); cycle();
    drive(1'b0, 1'b0, '0);
    check("fill_count1", W'(Count1), W'(2));
    #1;
    check("fill_ready_c0", W'(In_Ready), '0);
    Condition = 1'b1; #1;
    check("fill_ready_c1", W'(In_Ready), W'(1));
    drive(1'b1, 1'b0, 32'hA2);
    cycle();
    check("fill_third_count", W'(Count1), W'(2));
    check("fill_third_head", Data1, 32'hA0);

    // port 2 still flows while port 1 is full and stalled
    Out2_Ready = 1'b0;
    drive(1'b1, 1'b1, 32'hB0);
    cycle();
    drive(1'b0, 1'b0, '0);
    check("indep_valid2", W'(Out2_Valid), W'(1));
    check("indep_data2", Data2, 32'hB0);
    check("indep_data1", Data1, 32'hA0);
    cycle();
    check("stall_data1", Data1, 32'hA0);
    drain("drain_fill");

    // simultaneous push and pop
    Out1_Ready = 1'b0;
    drive(1'b1, 1'b0, 32'hC0); cycle();
    Out1_Ready = 1'b1;
    drive(1'b1, 1'b0, 32'hC1); cycle();
    drive(1'b0, 1'b0, '0);
    check("simul_count1", W'(Count1), W'(1));
    check("simul_data1", Data1, 32'hC1);
    cycle();
    check("simul_empty", W'(Count1), '0);

    // stream 0..9 to port 1 with toggling consumer
    for (int i = 0; i < 10; i++) begin
      logic done;
      done = 1'b0;
      for (int t = 0; t < 10 && !done; t++) begin
        drive(1'b1, 1'b0, W'(i));
        Out1_Ready = ~Out1_Ready;
        #1;
        done = In_Ready;
        cycle();
      end
      if (!done) check("stream_accept_timeout", W'(i), W'(i + 1));
    end
    drain("drain_stream");

    // random mixed traffic on both ports
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom));
      Out1_Ready = 1'($urandom_range(0, 1));
      Out2_Ready = 1'($urandom_range(0, 1));
      cycle();
    end
    drain("drain_random");

    // reset mid-stream overrides concurrent push and pop
    Out1_Ready = 1'b0;
    Out2_Ready = 1'b0;
    drive(1'b1, 1'b0, 32'hD0); cycle();
    drive(1'b1, 1'b1, 32'hE0); cycle();
    check("prerst_count1", W'(Count1), W'(1));
    check("prerst_count2", W'(Count2), W'(1));
    Reset      = 1'b1;
    Out1_Ready = 1'b1;
    drive(1'b1, 1'b0, 32'hF0);
    cycle();
    Reset = 1'b0;
    drive(1'b0, 1'b0, '0);
    check("midrst_count1", W'(Count1), '0);
    check("midrst_count2", W'(Count2), '0);
    check("midrst_valid", W'({Out1_Valid, Out2_Valid}), '0);
    check("midrst_data1", Data1, '0);
    check("midrst_data2", Data2, '0);
    cycle();
    check("midrst_no_store", W'(Count1), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
